// File: rtl/pb_event.sv
// Push-button event queue: captures button edges into a small FIFO readable over CPU I/O.
// Define PB_EVENT_FALL_EN to queue releases as well as presses.
module pb_event #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] state,
  input  logic [7:0] addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] out,
  output logic       irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [7:0]    ADDR_STATUS = 8'd251;
  localparam logic [7:0]    ADDR_DATA   = 8'd252;
  localparam logic [AW-1:0] PTR_LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(DEPTH);

  logic [4:0]    prev;
  logic [4:0]    edge_mask;
  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full, empty;
  logic          push, pop, wr_en;
  logic          ovf_event, ovf_clear;
  logic          unused_wdata;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

`ifdef PB_EVENT_FALL_EN
  assign edge_mask = state ^ prev;
`else
  assign edge_mask = state & ~prev;
`endif

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign push      = (edge_mask != 5'b0);
  assign pop       = rd && (addr == ADDR_DATA) && !empty;
  // A full queue still accepts a new entry when a pop frees a slot the same cycle.
  assign wr_en     = push && (!full || pop);
  assign ovf_event = push && full && !pop;
  assign ovf_clear = wr && (addr == ADDR_STATUS) && wdata[7];
  assign unused_wdata = ^wdata[6:0];

  // Control state: edge history, pointers, occupancy, sticky overflow, interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= 5'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      prev <= state;
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (pop)   rd_ptr <= next_ptr(rd_ptr);
      if (wr_en && !pop)      count <= count + CW'(1);
      else if (!wr_en && pop) count <= count - CW'(1);
      if (ovf_event)      overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
      irq <= !empty;
    end
  end

  // Entry storage carries data only and is never reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= edge_mask;
  end

  always_comb begin
    out = 8'b0;
    if (addr == ADDR_STATUS) begin
      out = {overflow, full, 2'b00, 4'(count)};
    end else if (addr == ADDR_DATA && !empty) begin
      out = {3'b000, mem[rd_ptr]};
    end
  end

endmodule

// File: tb/tb_pb_event.sv
// Directed self-checking bench for pb_event (DEPTH=8), covering both edge-mode builds.
module tb_pb_event;

  localparam int DEPTH = 8;
`ifdef PB_EVENT_FALL_EN
  localparam bit FALL = 1'b1;
`else
  localparam bit FALL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] state;
  logic [7:0] addr;
  logic       rd, wr;
  logic [7:0] wdata;
  logic [7:0] out;
  logic       irq;

  int n_checks = 0;
  int n_errors = 0;

  pb_event #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .state(state), .addr(addr), .rd(rd), .wr(wr),
    .wdata(wdata), .out(out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, out, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {7'b0, irq}, {7'b0, exp});
  endtask

  task automatic drain();
    addr = 8'd252;
    rd = 1'b1;
    repeat (DEPTH + 1) tick();
    rd = 1'b0;
  endtask

  task automatic press_release(input logic [4:0] m);
    state = m;
    tick();
    state = 5'b0;
    tick();
  endtask

  initial begin
    logic [4:0] masks [9];
    masks = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h03, 5'h05, 5'h06, 5'h09};
    rst = 1'b1; state = '0; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    repeat (2) tick();
    chk_irq("reset irq", 1'b0);
    chk_reg("reset status", 8'd251, 8'h00);
    rst = 1'b0;
    tick();

    // single press, interrupt timing, read and pop
    state = 5'b00001;
    tick();
    chk_reg("t1 status", 8'd251, 8'h01);
    chk_irq("t1 irq early", 1'b0);
    tick();
    chk_irq("t1 irq set", 1'b1);
    chk_reg("t1 data", 8'd252, 8'h01);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk_reg("t1 status popped", 8'd251, 8'h00);
    tick();
    chk_irq("t1 irq clear", 1'b0);
    state = 5'b0;
    tick();
    drain();
    chk_reg("t1 drained", 8'd251, 8'h00);

    // simultaneous edges form one entry
    state = 5'b10100;
    tick();
    chk_reg("t2 status", 8'd251, 8'h01);
    chk_reg("t2 data", 8'd252, 8'h14);
    state = 5'b0;
    tick();
    drain();

    // overflow with 9 press/release pairs
    for (int i = 0; i < 9; i++) press_release(masks[i]);
    chk_reg("t3 status full", 8'd251, 8'hC8);
    chk_reg("t3 first data", 8'd252, 8'h01);
    addr = 8'd251; wr = 1'b1; wdata = 8'h7F;
    tick();
    wr = 1'b0;
    chk_reg("t3 no clear bit7=0", 8'd251, 8'hC8);
    state = 5'b11111; addr = 8'd251; wr = 1'b1; wdata = 8'h80;
    tick();
    wr = 1'b0;
    chk_reg("t3 ovf wins clear", 8'd251, 8'hC8);
    state = 5'b0;
    tick();
    addr = 8'd251; wr = 1'b1; wdata = 8'h80;
    tick();
    wr = 1'b0;
    chk_reg("t3 cleared", 8'd251, 8'h48);

    // push and pop together while full
    state = 5'b01010; addr = 8'd252; rd = 1'b1;
    tick();
    rd = 1'b0;
    chk_reg("t4 full push+pop", 8'd251, 8'h48);
    addr = 8'd252; rd = 1'b1;
    repeat (DEPTH - 1) tick();
    rd = 1'b0;
    chk_reg("t4 tail entry", 8'd252, 8'h0A);
    chk_reg("t4 status", 8'd251, 8'h01);
    state = 5'b0;
    tick();
    drain();

    // read when empty, then reset with a partly filled queue
    addr = 8'd252; rd = 1'b1;
    tick();
    rd = 1'b0;
    chk_reg("t5 empty data", 8'd252, 8'h00);
    chk_reg("t5 empty status", 8'd251, 8'h00);
    state = 5'b00001; tick();
    state = 5'b00000; tick();
    state = 5'b00010; tick();
    state = 5'b00000; tick();
    state = 5'b00100; tick();
    chk_reg("t5 queued", 8'd251, FALL ? 8'h05 : 8'h03);
    chk_irq("t5 irq", 1'b1);
    rst = 1'b1;
    #1;
    chk_irq("t5 async irq", 1'b0);
    chk_reg("t5 async status", 8'd251, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk_reg("t5 held button edge", 8'd251, 8'h01);
    chk_reg("t5 held button data", 8'd252, 8'h04);

    // press and release button 2; stray accesses ignored
    drain();
    state = 5'b0;
    tick();
    drain();
    chk_reg("t6 empty", 8'd251, 8'h00);
    state = 5'b00100; tick();
    state = 5'b00000; tick();
    chk_reg("t6 other addr", 8'd250, 8'h00);
    addr = 8'd251; rd = 1'b1;
    tick();
    rd = 1'b0;
    chk_reg("t6 count", 8'd251, FALL ? 8'h02 : 8'h01);
    chk_reg("t6 data0", 8'd252, 8'h04);
    addr = 8'd252; rd = 1'b1;
    tick();
    rd = 1'b0;
    chk_reg("t6 data1", 8'd252, FALL ? 8'h04 : 8'h00);
    chk_reg("t6 count after pop", 8'd251, FALL ? 8'h01 : 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
